avalon_wait_ram: RTL and testbench
==================================

// Module: avalon_wait_ram
// PURPOSE
// - Avalon-MM slave (responder) word memory answering the CPU's bus master: address/read/write/
//   writedata/byteenable in, readdata/waitrequest out.
// - Inserts a programmable number of wait states per transfer to exercise the CPU's stall logic.
// - Side preload port writes program words before/while the CPU runs (testbench instruction load).
// PARAMETERS
// - DEPTH_LOG2   8  memory holds 2**DEPTH_LOG2 32-bit words
// - WAIT_CYCLES  2  extra waitrequest-high cycles per transfer (0..15)
// PORTS
// - clk          in   1   clock, all state updates on rising edge
// - reset        in   1   synchronous, active-high
// - address      in   32  byte address from master; word index = address[DEPTH_LOG2+1:2]
// - read         in   1   read request
// - write        in   1   write request
// - writedata    in   32  write data
// - byteenable   in   4   lane enables, bit n -> writedata[8n+7:8n]
// - waitrequest  out  1   high = master must hold request stable
// - readdata     out  32  read result, valid in the cycle waitrequest drops on a read
// - inst_input   in   1   preload enable
// - inst_addr    in   DEPTH_LOG2+2  preload byte address (word index = inst_addr[DEPTH_LOG2+1:2])
// - instruction  in   32  preload word
// BEHAVIOUR
// - FSM IDLE/BUSY/ACK, 4-bit wait counter cnt.
// - Reset: state=IDLE, cnt=0, readdata=0; memory contents NOT cleared.
// - waitrequest = (read|write) & (state!=ACK), combinational; 0 when no request.
// - IDLE, request seen: latch index, op (write wins if read&write both high), writedata, byteenable;
//   cnt<=WAIT_CYCLES; ->BUSY.
// - BUSY: cnt!=0 -> cnt<=cnt-1. cnt==0 -> perform access -> ACK:
//     - write: commit enabled byte lanes only
//     - read: readdata<=mem[index]
// - ACK: waitrequest=0, transfer completes this cycle; ->IDLE. A request still present is a new
//   transfer, accepted on the following cycle.
// - Latency: request first seen at edge 0; waitrequest low in cycle WAIT_CYCLES+2; readdata valid then.
// - readdata holds its value until the next read completes; writes do not alter it.
// - Master drops read/write while BUSY (protocol violation): ->IDLE, no commit, readdata unchanged.
// - Latched fields are used during BUSY; bus inputs changing mid-transfer are ignored.
// - byteenable=4'b0000 write: full handshake, memory unchanged.
// - address[1:0] ignored; address bits above DEPTH_LOG2+1 ignored (index wraps, no error).
// - Preload: inst_input=1 writes instruction to mem[inst_addr index] each edge, any state, also during
//   reset. Same word as a committing bus write in the same cycle: preload wins.
// - Read committing from a word being preloaded that cycle returns the old contents.
// - Reset mid-transfer: ->IDLE next edge, pending write discarded, readdata=0.
// CONFIGURATION
// - RAM_PROTOCOL_CHECK_EN defined:
//     - simulation-only checks; $error on read&write together, request dropped or
//       address/writedata/byteenable changed while waitrequest=1
//     - $error on WAIT_CYCLES>15 at elaboration
//     - datapath unchanged
// - Not defined: no checks; behaviour exactly as above, fully synthesizable.
// TESTING
// - Preload 0x24020010 at 0x04 via inst_input, read 0x04 -> waitrequest high 3 cycles, then readdata=0x24020010.
// - Write 0xDEADBEEF be=4'b1111 to 0x10, write 0x000000AA be=4'b0001 to 0x10, read -> 0xDEADBEAA.
// - WAIT_CYCLES=0: read 0x04 -> waitrequest high exactly 1 cycle; back-to-back reads each complete.
// - Assert reset during BUSY of write 0x12345678 to 0x20 -> read 0x20 returns prior value; readdata=0 after reset.
// - Read 0x404 with DEPTH_LOG2=8 -> returns contents of 0x04 (wrap).
// - Same-cycle preload 0x11111111 and committing bus write 0x22222222 to 0x08 -> read 0x08 = 0x11111111.

Source files
------------

// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram: Avalon-MM word RAM with programmable wait states and a side preload port.
// Define RAM_PROTOCOL_CHECK_EN to enable simulation-only bus protocol checks.
module avalon_wait_ram #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           address,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           writedata,
    input  logic [3:0]            byteenable,
    output logic                  waitrequest,
    output logic [31:0]           readdata,
    input  logic                  inst_input,
    input  logic [DEPTH_LOG2+1:0] inst_addr,
    input  logic [31:0]           instruction
);
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0]   idx_q, idx_d;
    logic                    wr_q, wr_d;
    logic [31:0]             wd_q, wd_d;
    logic [3:0]              be_q, be_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    req, commit;
    logic [31:0]             mem [2**DEPTH_LOG2];
    logic                    unused_ok;

    assign req         = read | write;
    assign waitrequest = req & (state_q != ACK);
    assign readdata    = rdata_q;
    assign unused_ok   = ^{address[31:DEPTH_LOG2+2], address[1:0], inst_addr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (req) begin
                idx_d   = address[DEPTH_LOG2+1:2];
                wr_d    = write;
                wd_d    = writedata;
                be_d    = byteenable;
                cnt_d   = 4'(WAIT_CYCLES);
                state_d = BUSY;
            end
            // A request withdrawn mid-transfer abandons it without touching memory.
            BUSY: if (!req) state_d = IDLE;
                  else if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                  else begin
                      commit  = 1'b1;
                      state_d = ACK;
                      rdata_d = wr_q ? rdata_q : mem[idx_q];
                  end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wd_q    <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    // Preload is assigned last so it overrides a bus write to the same word.
    always_ff @(posedge clk) begin
        if (commit && wr_q && !reset)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx_q][8*i +: 8] <= wd_q[8*i +: 8];
        if (inst_input) mem[inst_addr[DEPTH_LOG2+1:2]] <= instruction;
    end

`ifdef RAM_PROTOCOL_CHECK_EN
    if (WAIT_CYCLES > 15) begin : g_bad_wait
        $error("avalon_wait_ram: WAIT_CYCLES=%0d exceeds 15", WAIT_CYCLES);
    end

    logic        chk_wait_q;
    logic [31:0] chk_addr_q, chk_wd_q;
    logic [3:0]  chk_be_q;

    always_ff @(posedge clk) begin
        chk_wait_q <= waitrequest & !reset;
        chk_addr_q <= address;
        chk_wd_q   <= writedata;
        chk_be_q   <= byteenable;
        if (!reset && read && write)
            $error("avalon_wait_ram: read and write asserted together");
        if (!reset && chk_wait_q && (!req || address != chk_addr_q ||
                                     writedata != chk_wd_q || byteenable != chk_be_q))
            $error("avalon_wait_ram: request dropped or changed while waitrequest=1");
    end
`else
`endif
endmodule

// File: tb/tb_avalon_wait_ram.sv
// tb_avalon_wait_ram: directed bench for avalon_wait_ram with WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_avalon_wait_ram;
    logic        clk = 1'b0, reset = 1'b1, rq = 1'b0, wq = 1'b0, sel = 1'b0, inst_input = 1'b0;
    logic [31:0] address = 32'd0, writedata = 32'd0, instruction = 32'd0;
    logic [3:0]  byteenable = 4'd0;
    logic [9:0]  inst_addr = 10'd0;
    logic        wt2, wt0, wt;
    logic [31:0] rd2, rd0, rdm;
    int          tests = 0, fails = 0;
    int          n;
    logic [31:0] r;

    always #5 clk = ~clk;

    assign wt  = sel ? wt0 : wt2;
    assign rdm = sel ? rd0 : rd2;

    avalon_wait_ram #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .reset(reset), .address(address), .read(rq & ~sel), .write(wq & ~sel),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(wt2), .readdata(rd2),
        .inst_input(inst_input), .inst_addr(inst_addr), .instruction(instruction));

    avalon_wait_ram #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .reset(reset), .address(address), .read(rq & sel), .write(wq & sel),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(wt0), .readdata(rd0),
        .inst_input(inst_input), .inst_addr(inst_addr), .instruction(instruction));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts waitrequest-high samples until it drops; -1 on timeout.
    task automatic wait_ack(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!wt) return;
            cnt++;
        end
        cnt = -1;
    endtask

    task automatic start(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        address = a; writedata = d; byteenable = be; wq = w; rq = ~w;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        output int cnt, output logic [31:0] rdv);
        start(w, a, d, be);
        wait_ack(cnt);
        rdv = rdm;
        rq = 1'b0; wq = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input int en, input logic [31:0] ed);
        int c;
        logic [31:0] v;
        xfer(1'b0, a, 32'd0, 4'd0, c, v);
        chk({tag, "_wait"}, 32'(c), 32'(en));
        chk(tag, v, ed);
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input int en);
        int c;
        logic [31:0] v;
        xfer(1'b1, a, d, be, c, v);
        chk({tag, "_wait"}, 32'(c), 32'(en));
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        inst_input = 1'b1; inst_addr = a; instruction = d;
        @(negedge clk);
        inst_input = 1'b0;
    endtask

    initial begin
        preload(10'h00C, 32'hCAFEF00D);
        @(negedge clk);
        chk("rst_rdata2", rd2, 32'd0);
        chk("rst_rdata0", rd0, 32'd0);
        chk("rst_wait", {31'd0, wt2}, 32'd0);
        reset = 1'b0;

        preload(10'h004, 32'h24020010);
        rd_chk("pre_rd", 32'h04, 3, 32'h24020010);
        wr("wr_full", 32'h10, 32'hDEADBEEF, 4'b1111, 3);
        chk("rd_hold", rdm, 32'h24020010);
        wr("wr_lane", 32'h10, 32'h000000AA, 4'b0001, 3);
        rd_chk("lane", 32'h10, 3, 32'hDEADBEAA);
        wr("wr_be0", 32'h10, 32'hFFFFFFFF, 4'b0000, 3);
        rd_chk("be0", 32'h10, 3, 32'hDEADBEAA);
        rd_chk("wrap", 32'h404, 3, 32'h24020010);
        rd_chk("lsb", 32'h13, 3, 32'hDEADBEAA);
        rd_chk("rst_preload", 32'h0C, 3, 32'hCAFEF00D);
        wr("wr_prior", 32'h20, 32'hAAAA5555, 4'b1111, 3);
        rd_chk("prior", 32'h20, 3, 32'hAAAA5555);

        // reset lands on the edge that would commit the write
        start(1'b1, 32'h20, 32'h12345678, 4'b1111);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; wq = 1'b0;
        chk("rst_mid_rdata", rdm, 32'd0);
        rd_chk("rst_discard", 32'h20, 3, 32'hAAAA5555);

        start(1'b1, 32'h10, 32'h00000000, 4'b1111);
        @(negedge clk);
        wq = 1'b0;
        repeat (2) @(negedge clk);
        rd_chk("drop_wr", 32'h10, 3, 32'hDEADBEAA);
        start(1'b0, 32'h04, 32'd0, 4'd0);
        @(negedge clk);
        rq = 1'b0;
        repeat (2) @(negedge clk);
        chk("drop_rd", rdm, 32'hDEADBEAA);

        // preload and bus write hit word 0x08 on the same edge
        start(1'b1, 32'h08, 32'h22222222, 4'b1111);
        repeat (3) @(negedge clk);
        inst_input = 1'b1; inst_addr = 10'h008; instruction = 32'h11111111;
        @(negedge clk);
        inst_input = 1'b0;
        chk("pl_ack", {31'd0, wt}, 32'd0);
        wq = 1'b0;
        rd_chk("pl_wins", 32'h08, 3, 32'h11111111);
        start(1'b0, 32'h08, 32'd0, 4'd0);
        repeat (3) @(negedge clk);
        inst_input = 1'b1; inst_addr = 10'h008; instruction = 32'h33333333;
        @(negedge clk);
        inst_input = 1'b0;
        chk("pl_old", rdm, 32'h11111111);
        rq = 1'b0;
        rd_chk("pl_new", 32'h08, 3, 32'h33333333);

        sel = 1'b1;
        rd_chk("w0", 32'h04, 1, 32'h24020010);
        start(1'b0, 32'h04, 32'd0, 4'd0);
        wait_ack(n);
        chk("b2b1_wait", 32'(n), 32'd1);
        chk("b2b1", rdm, 32'h24020010);
        address = 32'h0C;
        wait_ack(n);
        r = rdm;
        rq = 1'b0;
        chk("b2b2_wait", 32'(n), 32'd2);
        chk("b2b2", r, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
